// File: rtl/zsy_glyph_writer.sv
// Draws one 16x16 glyph: fetches both 128-bit halves from the glyph ROM and streams
// the 38-byte page-addressed OLED write sequence (3 cmd + 16 data, twice) over valid/ready.
module zsy_glyph_writer #(
    parameter int ROM_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_glyph,
    input  logic [2:0]   cmd_page,
    input  logic [6:0]   cmd_col,
    output logic [3:0]   rom_addr,
    input  logic [127:0] rom_top,
    input  logic [127:0] rom_btm,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [7:0]   tx_data,
    output logic         tx_dc,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        IDLE,
        ROM_WAIT,
        CMD_TOP,
        DAT_TOP,
        CMD_BTM,
        DAT_BTM
    } state_t;

    state_t         state_reg;
    logic [2:0]     page_reg;
    logic [6:0]     col_reg;
    logic [127:0]   top_buf_reg;
    logic [127:0]   btm_buf_reg;
    logic [3:0]     cnt_reg;
    logic [7:0]     wait_reg;
    logic           cmd_ready_reg;
    logic [3:0]     rom_addr_reg;
    logic           tx_valid_reg;
    logic [7:0]     tx_data_reg;
    logic           tx_dc_reg;
    logic           busy_reg;
    logic           done_reg;

    logic           hs;
    logic [7:0]     col_lo_byte;
    logic [7:0]     col_hi_byte;

    assign hs          = tx_valid_reg && tx_ready;
    assign col_lo_byte = {4'h0, col_reg[3:0]};
    assign col_hi_byte = {5'b00010, col_reg[6:4]};

    assign cmd_ready = cmd_ready_reg;
    assign rom_addr  = rom_addr_reg;
    assign tx_valid  = tx_valid_reg;
    assign tx_data   = tx_data_reg;
    assign tx_dc     = tx_dc_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

    // Data bytes come off the top of a shifting buffer, so no 16:1 column mux is needed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            page_reg      <= 3'd0;
            col_reg       <= 7'd0;
            top_buf_reg   <= '0;
            btm_buf_reg   <= '0;
            cnt_reg       <= 4'd0;
            wait_reg      <= 8'd0;
            cmd_ready_reg <= 1'b0;
            rom_addr_reg  <= 4'd0;
            tx_valid_reg  <= 1'b0;
            tx_data_reg   <= 8'd0;
            tx_dc_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cmd_ready_reg <= 1'b1;
                    if (cmd_valid && cmd_ready_reg) begin
                        page_reg      <= cmd_page;
                        col_reg       <= cmd_col;
                        rom_addr_reg  <= cmd_glyph;
                        busy_reg      <= 1'b1;
                        cmd_ready_reg <= 1'b0;
                        wait_reg      <= 8'd0;
                        state_reg     <= ROM_WAIT;
                    end
                end
                ROM_WAIT: begin
                    if (wait_reg == 8'(ROM_LAT)) begin
                        top_buf_reg  <= rom_top;
                        btm_buf_reg  <= rom_btm;
                        tx_valid_reg <= 1'b1;
                        tx_data_reg  <= {5'b10110, page_reg};
                        tx_dc_reg    <= 1'b0;
                        cnt_reg      <= 4'd0;
                        state_reg    <= CMD_TOP;
                    end else begin
                        wait_reg <= wait_reg + 8'd1;
                    end
                end
                CMD_TOP, CMD_BTM: begin
                    if (hs) begin
                        cnt_reg <= cnt_reg + 4'd1;
                        if (cnt_reg == 4'd0) begin
                            tx_data_reg <= col_lo_byte;
                        end else if (cnt_reg == 4'd1) begin
                            tx_data_reg <= col_hi_byte;
                        end else begin
                            cnt_reg   <= 4'd0;
                            tx_dc_reg <= 1'b1;
                            if (state_reg == CMD_TOP) begin
                                tx_data_reg <= top_buf_reg[127:120];
                                top_buf_reg <= {top_buf_reg[119:0], 8'h00};
                                state_reg   <= DAT_TOP;
                            end else begin
                                tx_data_reg <= btm_buf_reg[127:120];
                                btm_buf_reg <= {btm_buf_reg[119:0], 8'h00};
                                state_reg   <= DAT_BTM;
                            end
                        end
                    end
                end
                DAT_TOP: begin
                    if (hs) begin
                        if (cnt_reg == 4'd15) begin
                            // Bottom half lands on the next page, wrapping 7 -> 0.
                            tx_data_reg <= {5'b10110, page_reg + 3'd1};
                            tx_dc_reg   <= 1'b0;
                            cnt_reg     <= 4'd0;
                            state_reg   <= CMD_BTM;
                        end else begin
                            tx_data_reg <= top_buf_reg[127:120];
                            top_buf_reg <= {top_buf_reg[119:0], 8'h00};
                            cnt_reg     <= cnt_reg + 4'd1;
                        end
                    end
                end
                DAT_BTM: begin
                    if (hs) begin
                        if (cnt_reg == 4'd15) begin
                            tx_valid_reg  <= 1'b0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                            cmd_ready_reg <= 1'b1;
                            cnt_reg       <= 4'd0;
                            state_reg     <= IDLE;
                        end else begin
                            tx_data_reg <= btm_buf_reg[127:120];
                            btm_buf_reg <= {btm_buf_reg[119:0], 8'h00};
                            cnt_reg     <= cnt_reg + 4'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/zsy_glyph_writer.md
Name: zsy_glyph_writer

Overview:
- Consumer of the 16x16 dot-matrix glyph ROM.
- Accepts a draw command (glyph index, OLED page, start column), reads the glyph's top and bottom 128-bit halves from the ROM, and streams a page-addressed OLED write sequence as bytes.
- The byte stream goes to the downstream serial shifter over a valid/ready handshake.
- Sits between the display-control logic and the OLED SPI transmitter.

Parameters:
- ROM_LAT, 1, clock edges from rom_addr change to valid rom_top/rom_btm (glyph ROM registers once).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous reset, active low.
- cmd_valid  in  1  draw command present.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_glyph  in  4  glyph index to draw.
- cmd_page  in  3  OLED page for the top half (0..7).
- cmd_col  in  7  OLED start column (0..127).
- rom_addr  out  4  address to glyph ROM.
- rom_top  in  128  glyph top page; column k = bits [127-8k : 120-8k].
- rom_btm  in  128  glyph bottom page, same packing.
- tx_valid  out  1  tx_data/tx_dc valid.
- tx_ready  in  1  downstream accepts byte.
- tx_data  out  8  byte to OLED.
- tx_dc  out  1  0 = command byte, 1 = display-data byte.
- busy  out  1  high from command accept until done.
- done  out  1  one-cycle pulse after the last byte handshake.

Behaviour:
- Reset (rst_n low at a rising edge) clears all of the following: cmd_ready=0 during reset, then 1 in IDLE; rom_addr=0; tx_valid=0; tx_data=0; tx_dc=0; busy=0; done=0; state=IDLE. Internal byte counter and glyph buffers are cleared.
- Command acceptance: a command is accepted on an edge with cmd_valid && cmd_ready. On that edge:
  - cmd_glyph, cmd_page and cmd_col are latched.
  - rom_addr <= cmd_glyph.
  - busy <= 1.
  - cmd_ready <= 0.
- States: IDLE -> ROM_WAIT -> CMD_TOP -> DAT_TOP -> CMD_BTM -> DAT_BTM -> IDLE.
- ROM_WAIT: count ROM_LAT edges after accept. On edge ROM_LAT+1 after accept:
  - capture rom_top/rom_btm into local 128-bit buffers;
  - tx_valid <= 1 with the first CMD_TOP byte.
  - With ROM_LAT=1, tx_valid rises 2 edges after accept.
- CMD_TOP (tx_dc=0) sends 3 bytes in order:
  - 0xB0 | page
  - 0x00 | col[3:0]
  - 0x10 | col[6:4]
- DAT_TOP (tx_dc=1) sends 16 bytes, top buffer column 0..15.
- CMD_BTM (tx_dc=0) sends 3 bytes:
  - 0xB0 | ((page+1) mod 8); page 7 wraps to page 0
  - the same two column bytes
- DAT_BTM (tx_dc=1) sends 16 bytes, bottom buffer column 0..15.
- Total: 38 bytes per command.
- Handshake:
  - A byte transfers on an edge with tx_valid && tx_ready.
  - The next byte is presented on that same edge, giving zero bubbles when tx_ready stays high.
  - While tx_valid && !tx_ready, tx_data and tx_dc hold stable and tx_valid stays high.
  - tx_valid never drops before its handshake.
- Column arithmetic: no clamping. Columns beyond 127 are left to the OLED's auto-increment; the block only emits the start column.
- Completion, on the handshake edge of byte 38:
  - tx_valid <= 0, busy <= 0, done <= 1 for exactly one cycle.
  - state <= IDLE and cmd_ready <= 1.
  - A new command can be accepted in the cycle done is high.
- cmd_valid asserted while busy is ignored (cmd_ready=0). The command fields are not re-sampled mid-operation.
- Unmapped glyph indices (ROM returns zeros) are still written, drawing a blank 16x16 cell of 32 zero data bytes.
- Reset mid-transfer: the transaction is abandoned immediately. tx_valid=0 on the reset edge, with no done pulse. The next command restarts from CMD_TOP byte 0.

Test Plan:
- Glyph 0, page 2, col 0x25, tx_ready=1 -> 38 consecutive bytes:
  - B2 05 12 (dc=0)
  - 00 00 00 00 F0 16 5C F0 58 D6 D2 30 10 00 00 00 (dc=1)
  - B3 05 12 (dc=0)
  - 00 04 04 04 04 05 05 7F 05 04 02 02 02 02 00 00 (dc=1)
  - tx_valid first high 2 edges after accept; done pulses once.
- Glyph 1, page 7, col 0x7F -> command bytes B7 0F 17, then B0 0F 17; data matches glyph 1 top/bottom halves.
- Glyph 9, page 0, col 0 -> B0 00 10, 16×00, B1 00 10, 16×00; done pulses.
- Glyph 2, random tx_ready toggling (~50%) -> identical 38-byte sequence as with tx_ready=1; tx_data/tx_dc stable during every stall; second cmd_valid pulse during busy is ignored.
- rst_n low for 1 cycle after byte 10 of glyph 0 -> tx_valid=0 on the reset edge, no done; a new command for glyph 1 then produces a full, correct 38-byte sequence.
- Back-to-back commands with cmd_valid held high -> second accepted in the done cycle; 76 total bytes; two done pulses.
